// File: rtl/cpu_trace_monitor.sv
// Trace unit beside the single-cycle CPU: captures committed register-file and
// data-memory writes with PC and cycle stamp into a FIFO drained over valid/ready.
//
// state    | meaning
// S_IDLE   | waiting for run_i, nothing captured
// S_RUN    | tracing; cycle_o counts traced cycles up to MAX_CYCLES
// S_DRAIN  | budget spent, inputs ignored, FIFO emptying
// S_DONE   | FIFO drained, done_o held until reset
module cpu_trace_monitor #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_IDX_W  = 5,
    parameter int DEPTH      = 16,
    parameter int CYCLE_W    = 16,
    parameter int MAX_CYCLES = 320
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic [ADDR_W-1:0]    pc_i,
    input  logic                 rf_we_i,
    input  logic [REG_IDX_W-1:0] rf_idx_i,
    input  logic [DATA_W-1:0]    rf_data_i,
    input  logic                 mem_we_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [DATA_W-1:0]    mem_data_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic                 rec_kind_o,
    output logic [CYCLE_W-1:0]   rec_cycle_o,
    output logic [ADDR_W-1:0]    rec_pc_o,
    output logic [ADDR_W-1:0]    rec_addr_o,
    output logic [DATA_W-1:0]    rec_data_o,
    output logic [CYCLE_W-1:0]   cycle_o,
    output logic [CYCLE_W-1:0]   drop_cnt_o,
    output logic                 overflow_o,
    output logic                 done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CYCLE_W-1:0] LAST_STAMP = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(DEPTH);

    typedef struct packed {
        logic               kind;
        logic [CYCLE_W-1:0] cycle;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    rec_t               fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               capture;
    logic               reg_cand;
    logic               mem_cand;
    logic               pop;
    logic [CNT_W-1:0]   free_slots;
    logic [1:0]         n_cand;
    logic [1:0]         n_push;
    logic [1:0]         n_drop;
    logic [CYCLE_W:0]   drop_sum;
    rec_t               reg_rec;
    rec_t               mem_rec;
    rec_t               slot0;
    rec_t               slot1;
    rec_t               shown;

    always_comb begin
        capture    = (state == S_RUN) && run_i;
        reg_cand   = capture && rf_we_i && (rf_idx_i != '0);
        mem_cand   = capture && mem_we_i;
        pop        = (count != '0) && rec_ready_i;
        // a pop in the same cycle frees its slot for this cycle's pushes
        free_slots = DEPTH_CNT - count + CNT_W'(pop);

        reg_rec.kind  = 1'b0;
        reg_rec.cycle = cycle_o;
        reg_rec.pc    = pc_i;
        reg_rec.addr  = ADDR_W'(rf_idx_i);
        reg_rec.data  = rf_data_i;

        mem_rec.kind  = 1'b1;
        mem_rec.cycle = cycle_o;
        mem_rec.pc    = pc_i;
        mem_rec.addr  = mem_addr_i;
        mem_rec.data  = mem_data_i;

        slot0  = reg_cand ? reg_rec : mem_rec;
        slot1  = mem_rec;
        n_cand = {1'b0, reg_cand} + {1'b0, mem_cand};

        if (free_slots >= CNT_W'(2)) begin
            n_push = n_cand;
        end else if (free_slots == CNT_W'(1)) begin
            n_push = (n_cand != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_push = 2'd0;
        end
        n_drop   = n_cand - n_push;
        drop_sum = {1'b0, drop_cnt_o} + (CYCLE_W + 1)'(n_drop);
    end

    assign rec_valid_o = (count != '0);
    assign shown       = rec_valid_o ? fifo_mem[rd_ptr] : '0;
    assign rec_kind_o  = shown.kind;
    assign rec_cycle_o = shown.cycle;
    assign rec_pc_o    = shown.pc;
    assign rec_addr_o  = shown.addr;
    assign rec_data_o  = shown.data;

    // storage is not reset; visibility is governed by count
    always_ff @(posedge clk_i) begin
        if (rst_n && (n_push != 2'd0)) begin
            fifo_mem[wr_ptr] <= slot0;
        end
        if (rst_n && (n_push == 2'd2)) begin
            fifo_mem[wr_ptr + PTR_W'(1)] <= slot1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cycle_o    <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_i) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_i) begin
                        cycle_o <= cycle_o + CYCLE_W'(1);
                        if (cycle_o == LAST_STAMP) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (n_drop != 2'd0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[CYCLE_W] ? '1 : drop_sum[CYCLE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: queue-based reference model checked every cycle,
// directed literal checks, randomized traffic, and a short-budget second instance.
module tb_cpu_trace_monitor;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int DEPTH      = 16;
    localparam int CYCLE_W    = 16;
    localparam int MAX_CYCLES = 320;
    localparam int SHORT_MAX  = 4;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 rst_n;
    logic                 run_i;
    logic [ADDR_W-1:0]    pc_i;
    logic                 rf_we_i;
    logic [REG_IDX_W-1:0] rf_idx_i;
    logic [DATA_W-1:0]    rf_data_i;
    logic                 mem_we_i;
    logic [ADDR_W-1:0]    mem_addr_i;
    logic [DATA_W-1:0]    mem_data_i;
    logic                 rec_valid_o;
    logic                 rec_ready_i;
    logic                 rec_kind_o;
    logic [CYCLE_W-1:0]   rec_cycle_o;
    logic [ADDR_W-1:0]    rec_pc_o;
    logic [ADDR_W-1:0]    rec_addr_o;
    logic [DATA_W-1:0]    rec_data_o;
    logic [CYCLE_W-1:0]   cycle_o;
    logic [CYCLE_W-1:0]   drop_cnt_o;
    logic                 overflow_o;
    logic                 done_o;

    logic                 s_run;
    logic [ADDR_W-1:0]    s_pc;
    logic                 s_rf_we;
    logic [REG_IDX_W-1:0] s_rf_idx;
    logic [DATA_W-1:0]    s_rf_data;
    logic                 s_mem_we;
    logic [ADDR_W-1:0]    s_mem_addr;
    logic [DATA_W-1:0]    s_mem_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_kind;
    logic [CYCLE_W-1:0]   s_rcyc;
    logic [ADDR_W-1:0]    s_rpc;
    logic [ADDR_W-1:0]    s_raddr;
    logic [DATA_W-1:0]    s_rdata;
    logic [CYCLE_W-1:0]   s_cycle;
    logic [CYCLE_W-1:0]   s_drop;
    logic                 s_ovf;
    logic                 s_done;

    cpu_trace_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W),
        .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES)
    ) u_dut (
        .clk_i(clk_i), .rst_n(rst_n), .run_i(run_i), .pc_i(pc_i),
        .rf_we_i(rf_we_i), .rf_idx_i(rf_idx_i), .rf_data_i(rf_data_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_kind_o(rec_kind_o),
        .rec_cycle_o(rec_cycle_o), .rec_pc_o(rec_pc_o), .rec_addr_o(rec_addr_o),
        .rec_data_o(rec_data_o), .cycle_o(cycle_o), .drop_cnt_o(drop_cnt_o),
        .overflow_o(overflow_o), .done_o(done_o)
    );

    cpu_trace_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W),
        .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .MAX_CYCLES(SHORT_MAX)
    ) u_short (
        .clk_i(clk_i), .rst_n(rst_n), .run_i(s_run), .pc_i(s_pc),
        .rf_we_i(s_rf_we), .rf_idx_i(s_rf_idx), .rf_data_i(s_rf_data),
        .mem_we_i(s_mem_we), .mem_addr_i(s_mem_addr), .mem_data_i(s_mem_data),
        .rec_valid_o(s_valid), .rec_ready_i(s_ready), .rec_kind_o(s_kind),
        .rec_cycle_o(s_rcyc), .rec_pc_o(s_rpc), .rec_addr_o(s_raddr),
        .rec_data_o(s_rdata), .cycle_o(s_cycle), .drop_cnt_o(s_drop),
        .overflow_o(s_ovf), .done_o(s_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: an ordered queue of records plus plain counters
    typedef struct {
        logic        kind;
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } mrec_t;

    mrec_t       mq[$];
    mrec_t       cand[$];
    mrec_t       r;
    int          m_phase;
    int unsigned m_cyc;
    int unsigned m_drops;
    bit          m_ovf;
    int          pre_sz;
    bit          m_pop;
    bit          chk_en = 0;

    always @(posedge clk_i) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = P_IDLE;
            m_cyc   = 0;
            m_drops = 0;
            m_ovf   = 0;
        end else begin
            pre_sz = mq.size();
            m_pop  = (pre_sz > 0) && rec_ready_i;
            cand.delete();
            if (m_pop) void'(mq.pop_front());
            if (m_phase == P_IDLE) begin
                if (run_i) m_phase = P_RUN;
            end else if (m_phase == P_RUN) begin
                if (run_i) begin
                    if (rf_we_i && rf_idx_i != 0) begin
                        r.kind = 1'b0; r.cyc = 16'(m_cyc); r.pc = pc_i;
                        r.addr = 32'(rf_idx_i); r.data = rf_data_i;
                        cand.push_back(r);
                    end
                    if (mem_we_i) begin
                        r.kind = 1'b1; r.cyc = 16'(m_cyc); r.pc = pc_i;
                        r.addr = mem_addr_i; r.data = mem_data_i;
                        cand.push_back(r);
                    end
                    if (m_cyc == MAX_CYCLES - 1) m_phase = P_DRAIN;
                    m_cyc++;
                end
            end else if (m_phase == P_DRAIN) begin
                if (pre_sz == 0) m_phase = P_DONE;
            end
            foreach (cand[i]) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(cand[i]);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("m_valid", rec_valid_o, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_kind", rec_kind_o, mq[0].kind);
                chk("m_rec_cycle", rec_cycle_o, mq[0].cyc);
                chk("m_rec_pc", rec_pc_o, mq[0].pc);
                chk("m_rec_addr", rec_addr_o, mq[0].addr);
                chk("m_rec_data", rec_data_o, mq[0].data);
            end
            chk("m_cycle", cycle_o, m_cyc);
            chk("m_drop", drop_cnt_o, m_drops);
            chk("m_ovf", overflow_o, m_ovf);
            chk("m_done", done_o, m_phase == P_DONE);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int    density;
    int    n;
    bit    will_pop;
    bit    exp_done_next;
    bit    got_done;
    int    o_cyc[$];
    int    o_data[$];
    int    o_addr[$];
    int    o_kind[$];

    initial begin
        rst_n = 0; run_i = 0; pc_i = '0; rf_we_i = 0; rf_idx_i = '0; rf_data_i = '0;
        mem_we_i = 0; mem_addr_i = '0; mem_data_i = '0; rec_ready_i = 0;
        s_run = 0; s_pc = '0; s_rf_we = 0; s_rf_idx = '0; s_rf_data = '0;
        s_mem_we = 0; s_mem_addr = '0; s_mem_data = '0; s_ready = 0;
        cyc(); cyc();

        chk("rst_valid", rec_valid_o, 0);
        chk("rst_kind", rec_kind_o, 0);
        chk("rst_rec_cycle", rec_cycle_o, 0);
        chk("rst_rec_pc", rec_pc_o, 0);
        chk("rst_rec_addr", rec_addr_o, 0);
        chk("rst_rec_data", rec_data_o, 0);
        chk("rst_cycle", cycle_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_done", done_o, 0);
        chk_en = 1;

        rst_n = 1; run_i = 1;
        cyc();
        pc_i = 32'h10; rf_we_i = 1; rf_idx_i = 5'd3; rf_data_i = 32'd7;
        cyc();
        chk("t1_valid", rec_valid_o, 1);
        chk("t1_kind", rec_kind_o, 0);
        chk("t1_stamp", rec_cycle_o, 0);
        chk("t1_pc", rec_pc_o, 32'h10);
        chk("t1_addr", rec_addr_o, 3);
        chk("t1_data", rec_data_o, 7);
        chk("t1_cycle", cycle_o, 1);

        rf_idx_i = 5'd0; rf_data_i = 32'd99; mem_we_i = 1; mem_addr_i = 32'h8;
        mem_data_i = 32'd5; pc_i = 32'h14;
        cyc();
        rf_we_i = 0; mem_we_i = 0; rec_ready_i = 1;
        cyc();
        chk("t2_valid", rec_valid_o, 1);
        chk("t2_kind", rec_kind_o, 1);
        chk("t2_stamp", rec_cycle_o, 1);
        chk("t2_addr", rec_addr_o, 32'h8);
        chk("t2_data", rec_data_o, 5);
        cyc();
        chk("t2_empty", rec_valid_o, 0);

        rec_ready_i = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            rf_we_i = 1; rf_idx_i = 5'($urandom_range(1, 31));
            rf_data_i = $urandom; pc_i = $urandom;
            cyc();
        end
        chk("t3_no_drop_yet", drop_cnt_o, 0);
        mem_we_i = 1; mem_addr_i = $urandom; mem_data_i = $urandom;
        cyc();
        chk("t3_drop_one", drop_cnt_o, 1);
        chk("t3_ovf", overflow_o, 1);
        cyc();
        chk("t3_drop_three", drop_cnt_o, 3);
        mem_we_i = 0; rec_ready_i = 1;
        cyc();
        chk("t3_full_pushpop_drop", drop_cnt_o, 3);
        rf_we_i = 0;
        repeat (DEPTH) cyc();
        chk("t3_drained", rec_valid_o, 0);
        chk("t3_cycle", cycle_o, 38);

        run_i = 0; rf_we_i = 1; rf_idx_i = 5'd9; mem_we_i = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_cycle_hold", cycle_o, 38);
            chk("t4_no_rec", rec_valid_o, 0);
        end
        run_i = 1; rf_we_i = 0; mem_we_i = 0;
        cyc();
        chk("t4_resume", cycle_o, 39);

        rec_ready_i = 0; rf_we_i = 1;
        for (int i = 0; i < 3; i++) begin
            rf_idx_i = 5'(i + 1); rf_data_i = $urandom;
            cyc();
        end
        chk("t6_queued", rec_valid_o, 1);
        rst_n = 0; rf_we_i = 0;
        cyc();
        chk("t6_valid", rec_valid_o, 0);
        chk("t6_cycle", cycle_o, 0);
        chk("t6_drop", drop_cnt_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_done", done_o, 0);
        rst_n = 1; run_i = 1; rf_we_i = 1; rf_idx_i = 5'd4; mem_we_i = 1;
        cyc();
        chk("t6_idle_no_capture", rec_valid_o, 0);
        chk("t6_idle_cycle", cycle_o, 0);

        density = 2;
        n = 0;
        while (m_phase != P_DONE && n < 4000) begin
            if (n % 64 == 0) density = $urandom_range(0, 4);
            run_i       = ($urandom % 8) != 0;
            rf_we_i     = $urandom_range(0, 1);
            rf_idx_i    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rf_data_i   = $urandom;
            mem_we_i    = $urandom_range(0, 1);
            mem_addr_i  = $urandom;
            mem_data_i  = $urandom;
            pc_i        = $urandom;
            rec_ready_i = ($urandom_range(0, 3) < density);
            cyc();
            n++;
        end
        chk("rand_done", done_o, 1);
        chk("rand_final_cycle", cycle_o, MAX_CYCLES);
        rec_ready_i = 1; run_i = 1;
        repeat (8) begin
            rf_we_i = 1; rf_idx_i = 5'($urandom_range(1, 31)); mem_we_i = 1;
            cyc();
        end
        chk("done_ignores_valid", rec_valid_o, 0);
        chk("done_holds", done_o, 1);
        run_i = 0; rf_we_i = 0; mem_we_i = 0;

        s_run = 1;
        cyc();
        exp_done_next = 0;
        got_done = 0;
        for (int k = 0; k < 60 && !got_done; k++) begin
            s_rf_we = 1; s_rf_idx = 5'(k % 31 + 1); s_rf_data = 32'(k);
            s_pc = 32'(k * 4); s_ready = (k % 2 == 1);
            will_pop = s_valid && s_ready;
            if (will_pop) begin
                o_cyc.push_back(int'(s_rcyc)); o_data.push_back(int'(s_rdata));
                o_addr.push_back(int'(s_raddr)); o_kind.push_back(int'(s_kind));
            end
            cyc();
            if (exp_done_next) begin
                chk("short_done_after_last_pop", s_done, 1);
                got_done = 1;
            end else begin
                if (s_valid) chk("short_no_done_while_valid", s_done, 0);
                if (will_pop && !s_valid && k >= SHORT_MAX - 1) begin
                    chk("short_done_low_at_last_pop", s_done, 0);
                    exp_done_next = 1;
                end
            end
        end
        chk("short_done_seen", got_done, 1);
        chk("short_rec_count", o_cyc.size(), SHORT_MAX);
        foreach (o_cyc[i]) begin
            chk("short_stamp", o_cyc[i], i);
            chk("short_data", o_data[i], i);
            chk("short_addr", o_addr[i], i + 1);
            chk("short_kind", o_kind[i], 0);
        end
        chk("short_cycle_final", s_cycle, SHORT_MAX);
        s_ready = 1; s_mem_we = 1;
        repeat (5) cyc();
        chk("short_ignored_valid", s_valid, 0);
        chk("short_ignored_done", s_done, 1);
        chk("short_ignored_cycle", s_cycle, SHORT_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
